// File: rtl/hilo_reg_pkg.sv
// Shared types for the HI/LO register pair and its EX-stage forwarding.
// Widths: 32-bit HI/LO words, 8-bit commit counter.
package hilo_reg_pkg;

  localparam int REG_W = 32;
  localparam int CNT_W = 8;

  typedef logic [REG_W-1:0] word_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam word_t ZERO_WORD = '0;

  typedef struct packed {
    logic  we;
    word_t hi;
    word_t lo;
  } hilo_wr_t;

  typedef struct packed {
    word_t hi;
    word_t lo;
  } hilo_t;

  function automatic cnt_t cnt_inc(cnt_t c);
    return c + cnt_t'(1);
  endfunction

endpackage

// File: rtl/hilo_reg_if.sv
// HI/LO port bundle: MEM/WB write sources, EX read request and results.
// slave = hilo_reg, master = surrounding pipeline.
interface hilo_reg_if;
  import hilo_reg_pkg::*;

  logic  wb_whilo;
  word_t wb_hi_i;
  word_t wb_lo_i;
  logic  mem_whilo;
  word_t mem_hi_i;
  word_t mem_lo_i;
  logic  ex_rd_hilo;
  word_t hi_o;
  word_t lo_o;
  word_t ex_hi_o;
  word_t ex_lo_o;
  logic  stall_req_o;
  cnt_t  commit_cnt_o;

  modport slave (
    input  wb_whilo, wb_hi_i, wb_lo_i,
    input  mem_whilo, mem_hi_i, mem_lo_i,
    input  ex_rd_hilo,
    output hi_o, lo_o, ex_hi_o, ex_lo_o,
    output stall_req_o, commit_cnt_o
  );

  modport master (
    output wb_whilo, wb_hi_i, wb_lo_i,
    output mem_whilo, mem_hi_i, mem_lo_i,
    output ex_rd_hilo,
    input  hi_o, lo_o, ex_hi_o, ex_lo_o,
    input  stall_req_o, commit_cnt_o
  );

endinterface

// File: rtl/hilo_fwd.sv
// EX-stage HI/LO source select; HILO_BYPASS_EN picks forwarding,
// otherwise EX reads architectural state and a hazard flag is raised.
module hilo_fwd
  import hilo_reg_pkg::*;
(
  input  hilo_wr_t wb,
  input  hilo_wr_t mem,
  input  hilo_t    arch,
  output hilo_t    ex,
  output logic     hazard
);

`ifdef HILO_BYPASS_EN
  // MEM holds the younger write, so it outranks WB.
  always_comb begin
    ex     = arch;
    hazard = 1'b0;
    priority case (1'b1)
      mem.we:  ex = '{hi: mem.hi, lo: mem.lo};
      wb.we:   ex = '{hi: wb.hi, lo: wb.lo};
      default: ex = arch;
    endcase
  end
`else
  logic unused_data;

  assign unused_data = ^{wb.hi, wb.lo, mem.hi, mem.lo};

  always_comb begin
    ex     = arch;
    hazard = mem.we | wb.we;
  end
`endif

endmodule

// File: rtl/hilo_reg.sv
// Architectural HI/LO pair with commit counter and EX read path.
// Build option: HILO_BYPASS_EN enables MEM/WB forwarding instead of stalling.
module hilo_reg
  import hilo_reg_pkg::*;
(
  input  logic       clk,
  input  logic       Rst_n,
  hilo_reg_if.slave  bus
);

  hilo_t    arch_d, arch_q;
  cnt_t     cnt_d, cnt_q;
  hilo_wr_t wb_wr, mem_wr;
  hilo_t    ex_val;
  logic     hazard;

  assign wb_wr  = {bus.wb_whilo, bus.wb_hi_i, bus.wb_lo_i};
  assign mem_wr = {bus.mem_whilo, bus.mem_hi_i, bus.mem_lo_i};

  always_comb begin
    arch_d = arch_q;
    cnt_d  = cnt_q;
    if (bus.wb_whilo) begin
      arch_d = '{hi: bus.wb_hi_i, lo: bus.wb_lo_i};
      cnt_d  = cnt_inc(cnt_q);
    end
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      arch_q <= '{hi: ZERO_WORD, lo: ZERO_WORD};
      cnt_q  <= '0;
    end else begin
      arch_q <= arch_d;
      cnt_q  <= cnt_d;
    end
  end

  hilo_fwd u_fwd (
    .wb     (wb_wr),
    .mem    (mem_wr),
    .arch   (arch_q),
    .ex     (ex_val),
    .hazard (hazard)
  );

  assign bus.hi_o         = arch_q.hi;
  assign bus.lo_o         = arch_q.lo;
  assign bus.commit_cnt_o = cnt_q;
  assign bus.ex_hi_o      = ex_val.hi;
  assign bus.ex_lo_o      = ex_val.lo;
  // Held low during reset regardless of pending writes.
  assign bus.stall_req_o  = Rst_n & bus.ex_rd_hilo & hazard;

endmodule

// File: tb/tb_hilo_reg.sv
// Scoreboard bench for hilo_reg: stimulus queues expectations,
// a negedge monitor pops and compares.
module tb_hilo_reg;
  import hilo_reg_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  hilo_reg_if bus();

  hilo_reg dut (
    .clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string nm;
    word_t hi;
    word_t lo;
    word_t ehi;
    word_t elo;
    logic  stall;
    cnt_t  cnt;
  } exp_t;

  exp_t  q[$];
  int    n_chk  = 0;
  int    n_fail = 0;
  word_t hi_m   = '0;
  word_t lo_m   = '0;
  cnt_t  cnt_m  = '0;

  task automatic chk(input string nm, input string f,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h want %h", nm, f, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk(e.nm, "hi_o", bus.hi_o, e.hi);
      chk(e.nm, "lo_o", bus.lo_o, e.lo);
      chk(e.nm, "ex_hi_o", bus.ex_hi_o, e.ehi);
      chk(e.nm, "ex_lo_o", bus.ex_lo_o, e.elo);
      chk(e.nm, "stall", {31'b0, bus.stall_req_o}, {31'b0, e.stall});
      chk(e.nm, "cnt", {24'b0, bus.commit_cnt_o}, {24'b0, e.cnt});
    end
  end

  task automatic step(input logic r, input logic w,
                      input word_t wh, input word_t wl,
                      input logic m, input word_t mh, input word_t ml,
                      input logic rd, input string nm);
    exp_t e;
    @(posedge clk);
    if (rst_n === 1'b1 && bus.wb_whilo === 1'b1) begin
      hi_m  = bus.wb_hi_i;
      lo_m  = bus.wb_lo_i;
      cnt_m = cnt_m + 8'd1;
    end
    #1;
    rst_n          = r;
    bus.wb_whilo   = w;
    bus.wb_hi_i    = wh;
    bus.wb_lo_i    = wl;
    bus.mem_whilo  = m;
    bus.mem_hi_i   = mh;
    bus.mem_lo_i   = ml;
    bus.ex_rd_hilo = rd;
    if (!r) begin
      hi_m  = '0;
      lo_m  = '0;
      cnt_m = '0;
    end
    e.nm  = nm;
    e.hi  = hi_m;
    e.lo  = lo_m;
    e.cnt = cnt_m;
`ifdef HILO_BYPASS_EN
    e.ehi   = m ? mh : (w ? wh : hi_m);
    e.elo   = m ? ml : (w ? wl : lo_m);
    e.stall = 1'b0;
`else
    e.ehi   = hi_m;
    e.elo   = lo_m;
    e.stall = r & rd & (m | w);
`endif
    q.push_back(e);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.wb_whilo   = 1'b0;
    bus.wb_hi_i    = '0;
    bus.wb_lo_i    = '0;
    bus.mem_whilo  = 1'b0;
    bus.mem_hi_i   = '0;
    bus.mem_lo_i   = '0;
    bus.ex_rd_hilo = 1'b0;

    step(0, 0, 0, 0, 0, 0, 0, 0, "rst0");
    step(0, 1, 32'h5, 32'h6, 0, 0, 0, 1, "rst1");
    step(1, 0, 0, 0, 0, 0, 0, 0, "idle");

    step(1, 1, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 0, 0, "commit_drv");
    step(1, 0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0, 0, 0, 0, "commit_vis");
    step(1, 0, 32'h1111_1111, 32'h2222_2222, 0, 0, 0, 0, "hold");

    step(1, 1, 32'h1, 32'h2, 0, 0, 0, 0, "arch1");
    step(1, 0, 0, 0, 1, 32'hAAAA_0000, 32'hAAAA_0001, 1, "mem_byp");
    step(1, 1, 32'h0000_BBBB, 32'h0000_BBBC,
         1, 32'hAAAA_0000, 32'hAAAA_0001, 1, "mem_wb_both");
    step(1, 0, 0, 0, 0, 0, 0, 1, "bbbb_vis");

    step(1, 0, 0, 0, 1, 32'h5555_6666, 32'h7777_8888, 1, "stall_mem");
    step(1, 1, 32'h5555_6666, 32'h7777_8888, 0, 0, 0, 1, "stall_wb");
    step(1, 0, 0, 0, 0, 0, 0, 1, "stall_clear");
    step(1, 1, 32'h0BAD_0001, 32'h0BAD_0002,
         1, 32'h0BAD_0003, 32'h0BAD_0004, 0, "no_rd");
    step(1, 0, 0, 0, 0, 0, 0, 0, "no_rd_vis");

    step(0, 0, 0, 0, 0, 0, 0, 0, "async_rst");
    step(1, 0, 0, 0, 0, 0, 0, 0, "release");

    for (int i = 0; i < 256; i++)
      step(1, 1, word_t'(i), ~word_t'(i), 0, 0, 0, 0, "wrap_loop");
    step(1, 1, 32'hF00D_0001, 32'hF00D_0002, 0, 0, 0, 0, "wrap_0");
    step(1, 0, 0, 0, 0, 0, 0, 0, "wrap_1");

    step(1, 0, 0, 0, 0, 0, 0, 0, "pre_rst");
    step(0, 1, 32'hFFFF_FFFF, 32'hEEEE_EEEE, 0, 0, 0, 1, "rst_pend_a");
    step(0, 1, 32'hFFFF_FFFF, 32'hEEEE_EEEE, 0, 0, 0, 1, "rst_pend_b");
    step(1, 0, 0, 0, 0, 0, 0, 0, "rst_pend_rel");
    step(1, 0, 0, 0, 0, 0, 0, 0, "final");

    for (int k = 0; k < 4 && q.size() > 0; k++)
      @(negedge clk);
    #2;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
